// File: rtl/bcd_counter_n.sv
// Synchronous multi-digit BCD up/down counter with load, wrap/saturate mode,
// terminal-count flag and registered carry pulse. Optional clr port: BCD_COUNTER_SYNC_CLR_EN.
module bcd_counter_n #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WRAP   = 1
) (
   input  logic                  clock,
   input  logic                  reset,
`ifdef BCD_COUNTER_SYNC_CLR_EN
   input  logic                  clr,
`endif
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  carry
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] r_q;
   logic         r_carry;
   logic [W-1:0] w_load_q;
   logic [W-1:0] w_step_q;
   logic [W-1:0] w_q_nxt;
   logic         w_carry_nxt;
   logic         w_all9;
   logic         w_all0;
   logic         w_tc;
   logic         w_clr;

`ifdef BCD_COUNTER_SYNC_CLR_EN
   assign w_clr = clr;
`else
   assign w_clr = 1'b0;
`endif

   // Sanitised load value, single-step value and terminal detection, all digits in parallel
   always_comb begin
      logic [3:0] v_d;
      logic [3:0] v_l;
      logic       v_ripple;
      w_load_q = '0;
      w_step_q = '0;
      w_all9   = 1'b1;
      w_all0   = 1'b1;
      v_ripple = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         v_d = r_q[4*i +: 4];
         v_l = load_val[4*i +: 4];
         w_load_q[4*i +: 4] = (v_l > 4'd9) ? 4'd0 : v_l;
         if (!v_ripple)
            w_step_q[4*i +: 4] = v_d;
         else if (up)
            w_step_q[4*i +: 4] = (v_d == 4'd9) ? 4'd0 : 4'(v_d + 4'd1);
         else
            w_step_q[4*i +: 4] = (v_d == 4'd0) ? 4'd9 : 4'(v_d - 4'd1);
         v_ripple = v_ripple && (up ? (v_d == 4'd9) : (v_d == 4'd0));
         w_all9   = w_all9 && (v_d == 4'd9);
         w_all0   = w_all0 && (v_d == 4'd0);
      end
   end

   assign w_tc = up ? w_all9 : w_all0;

   // Edge priority: clr, load, en, hold; carry is a one-cycle pulse
   always_comb begin
      w_q_nxt     = r_q;
      w_carry_nxt = 1'b0;
      if (w_clr) begin
         w_q_nxt = '0;
      end else if (load) begin
         w_q_nxt = w_load_q;
      end else if (en) begin
         if (!w_tc) begin
            w_q_nxt = w_step_q;
         end else if (WRAP != 0) begin
            w_q_nxt     = w_step_q;
            w_carry_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q     <= '0;
         r_carry <= 1'b0;
      end else begin
         r_q     <= w_q_nxt;
         r_carry <= w_carry_nxt;
      end
   end

   assign q     = r_q;
   assign carry = r_carry;
   assign tc    = w_tc;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: a wrapping and a saturating instance share
// stimulus; an integer-arithmetic model predicts q/carry, a monitor compares.
module tb_bcd_counter_n;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 4 * DIGITS;
   localparam int          MAXV   = 9999;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         clr   = 1'b0;
   logic         en    = 1'b0;
   logic         up    = 1'b1;
   logic         load  = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q_w, q_s;
   logic         tc_w, tc_s, carry_w, carry_s;

   typedef struct {
      int m_w;
      bit c_w;
      int m_s;
      bit c_s;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   mw = 0, ms = 0;
   bit   cw = 1'b0, cs = 1'b0;
   event ev_mid;

   bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1)) u_wrap (
      .clock(clock), .reset(reset),
`ifdef BCD_COUNTER_SYNC_CLR_EN
      .clr(clr),
`endif
      .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q_w), .tc(tc_w), .carry(carry_w));

   bcd_counter_n #(.DIGITS(DIGITS), .WRAP(0)) u_sat (
      .clock(clock), .reset(reset),
`ifdef BCD_COUNTER_SYNC_CLR_EN
      .clr(clr),
`endif
      .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q_s), .tc(tc_s), .carry(carry_s));

   always #5 clock = ~clock;

   function automatic logic [W-1:0] to_bcd(input int m);
      logic [W-1:0] r;
      int v;
      r = '0;
      v = m;
      for (int i = 0; i < int'(DIGITS); i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int from_load(input logic [W-1:0] lv);
      int v, scale, nib;
      v = 0;
      scale = 1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         nib = int'(lv[4*i +: 4]);
         if (nib > 9) nib = 0;
         v = v + nib * scale;
         scale = scale * 10;
      end
      return v;
   endfunction

   task automatic model_edge(input bit wrap, inout int m, inout bit c);
      bit cl;
      cl = 1'b0;
`ifdef BCD_COUNTER_SYNC_CLR_EN
      cl = clr;
`endif
      if (!reset || cl) begin
         m = 0; c = 1'b0;
      end else if (load) begin
         m = from_load(load_val); c = 1'b0;
      end else if (en) begin
         c = 1'b0;
         if (up && m == MAXV) begin
            if (wrap) begin m = 0; c = 1'b1; end
         end else if (!up && m == 0) begin
            if (wrap) begin m = MAXV; c = 1'b1; end
         end else begin
            m = up ? m + 1 : m - 1;
         end
      end else begin
         c = 1'b0;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.m_w = mw; e.c_w = cw; e.m_s = ms; e.c_s = cs;
      exp_q.push_back(e);
   endtask

   // Drive inputs at the falling edge and predict the following rising edge
   task automatic step(input bit i_en, input bit i_up, input bit i_load,
                       input logic [W-1:0] i_lv, input bit i_clr);
      @(negedge clock);
      en = i_en; up = i_up; load = i_load; load_val = i_lv; clr = i_clr;
      model_edge(1'b1, mw, cw);
      model_edge(1'b0, ms, cs);
      push_exp();
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Monitor: pops one expectation per rising edge (or mid-cycle reset event)
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or ev_mid);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("q_wrap",     q_w,                 to_bcd(e.m_w));
            chk("carry_wrap", W'(carry_w),         W'(e.c_w));
            chk("tc_wrap",    W'(tc_w),            W'(up ? (e.m_w == MAXV) : (e.m_w == 0)));
            chk("q_sat",      q_s,                 to_bcd(e.m_s));
            chk("carry_sat",  W'(carry_s),         W'(e.c_s));
            chk("tc_sat",     W'(tc_s),            W'(up ? (e.m_s == MAXV) : (e.m_s == 0)));
         end
      end
   end

   initial begin
      logic [W-1:0] lv;
      int           r;
      int           wait_cnt;
      // Reset held low across edges
      repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      en = 1'b0;
      // Twelve up edges from zero
      repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      // Up wrap from 9998
      step(1'b0, 1'b1, 1'b1, 16'h9998, 1'b0);
      repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      // Down wrap from 0001
      step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      // Load priority and invalid-digit sanitising
      step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h12F5, 1'b0);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      // Asynchronous reset mid-cycle
      step(1'b0, 1'b1, 1'b1, 16'h0457, 1'b0);
      @(posedge clock);
      #3;
      reset = 1'b0;
      mw = 0; cw = 1'b0; ms = 0; cs = 1'b0;
      push_exp();
      -> ev_mid;
      repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      // Saturation at 9999 (wrap instance wraps alongside)
      step(1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
`ifdef BCD_COUNTER_SYNC_CLR_EN
      step(1'b0, 1'b1, 1'b1, 16'h0457, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
`endif
      // Randomised traffic biased towards terminal values
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         for (int d = 0; d < int'(DIGITS); d++) lv[4*d +: 4] = 4'($urandom_range(0, 15));
         if (r < 4)       lv = 16'h9998;
         else if (r < 8)  lv = 16'h0001;
         else if (r < 10) lv = 16'h9999;
         step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 12), lv, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      // Drain the scoreboard with a bounded wait
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         @(posedge clock);
         wait_cnt++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Synchronous, parametrised multi-digit BCD (decade) counter.
- Next generation of the team's single-digit ripple decade counter. All digits share one clock edge, so there is no ripple skew.
- Adds up/down counting, count enable, parallel load, wrap or saturate mode, a terminal-count flag and a registered carry/borrow pulse.
- Used as a display/event counter feeding 7-segment decoders and cascades to wider counts via carry.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); counter width is 4*DIGITS bits.
- WRAP, 1, 1 = wrap around at the terminal value; 0 = saturate at the terminal value.

Ports:
- clock  input  1  counter clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; forces all state to 0 immediately.
- en  input  1  count enable; 1 = step by one this edge.
- up  input  1  direction; 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- q  output  4*DIGITS  current count in BCD; digit 0 is the least significant digit.
- tc  output  1  combinational terminal count: (up && q==all 9s) || (!up && q==all 0s).
- carry  output  1  registered one-cycle pulse marking a wrap event.

Behaviour:
- Reset (reset==0, asynchronous): q=0 and carry=0. Held while reset is low. On release, counting starts at the first rising edge with en=1.
- Edge priority (highest first): load, then en, then hold.
- Load:
  - q <= load_val, digit by digit.
  - Any digit greater than 9 in load_val is loaded as 0; other digits are unaffected.
  - carry <= 0 on a load edge.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - Digit i increments only when all lower digits are 9. A digit at 9 that increments becomes 0.
  - All digits update on the same edge, so q never shows an intermediate value.
- Count down (en=1, up=0):
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits are 0. A digit at 0 that decrements becomes 9.
- Terminal edge (en=1 while tc=1):
  - WRAP=1: q goes to all 0s (counting up) or all 9s (counting down), and carry <= 1.
  - WRAP=0: q holds at the terminal value and carry <= 0.
- carry:
  - Asserted in the cycle after the terminal edge, i.e. coincident with the wrapped q.
  - Cleared on the next edge unless another wrap occurs. With DIGITS=1 and continuous en, carry pulses once every 10 edges.
- Hold (en=0, load=0): q and carry hold, except that carry always clears after one cycle.
- Direction change: up is sampled at each edge. tc re-evaluates combinationally as soon as up changes.
- Reset mid-count: q and carry clear asynchronously. No partial digit update is ever visible.
- Latency: one clock from the load or en edge to the new q. tc has zero-cycle combinational latency from q and up.
- No internal state exists beyond q and carry.

Optional Feature:
- Macro: BCD_COUNTER_SYNC_CLR_EN.
- Defined:
  - Adds input port clr (1 bit).
  - clr=1 at an edge sets q <= 0 and carry <= 0.
  - clr has priority over load and en.
- Undefined:
  - No clr port exists.
  - Priority is load, then en, then hold, as in Behaviour.

Test Plan:
- DIGITS=4, WRAP=1:
  - Reset low, then release; en=1, up=1 for 12 edges -> q=0x0012; carry never asserted.
  - load_val=0x9998, up=1, two en edges -> q=0x9999 with tc=1, then q=0x0000 with carry=1 for exactly one cycle.
  - load_val=0x0001, up=0, two en edges -> q=0x0000 with tc=1, then q=0x9999 with carry=1.
  - load and en both 1, load_val=0x1234 -> q=0x1234, no increment; load_val=0x12F5 -> q=0x1205.
  - Drop reset to 0 asynchronously while q=0x0457 mid-cycle -> q=0x0000 and carry=0 before the next clock edge; values hold while reset is low.
- DIGITS=4, WRAP=0:
  - From 0x9999, up=1, three en edges -> q stays 0x9999, carry=0, tc=1.
- DIGITS=4, BCD_COUNTER_SYNC_CLR_EN defined:
  - clr=1, load=1 and en=1 on the same edge -> q=0x0000.
